// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit.
// Multiplies with radix-2 shift-add and divides with restoring division over
// 32 iterations. It works on operand magnitudes and restores the signs in a
// single fixup cycle. Divide-by-zero and signed overflow complete directly
// from IDLE.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [4:0]      ALU_OP,
    input  logic [XLEN-1:0] OPERAND1,
    input  logic [XLEN-1:0] OPERAND2,
    output logic            BUSY,
    output logic            DONE,
    output logic [XLEN-1:0] RESULT
);

    localparam int unsigned CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [2:0]          op_q;
    logic                neg1_q;
    logic                neg2_q;
    logic [XLEN-1:0]     a_q;
    logic [XLEN-1:0]     b_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [CW-1:0]       cnt_q;
    logic                init_q;
    logic                done_q;
    logic [XLEN-1:0]     result_q;

    logic                accept;
    logic                in_div;
    logic                in_neg1;
    logic                in_neg2;
    logic [XLEN-1:0]     mag1;
    logic [XLEN-1:0]     mag2;
    logic                special;
    logic [XLEN-1:0]     special_result;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_trial;
    logic [2*XLEN-1:0]   div_next;
    logic [2*XLEN-1:0]   mul_fix;
    logic [XLEN-1:0]     q_fix;
    logic [XLEN-1:0]     r_fix;
    logic [XLEN-1:0]     fix_result;

    // Decode the request: operand signedness, magnitudes and early-out cases.
    always_comb begin
        accept  = (state_q == S_IDLE) && START && (ALU_OP[4:3] == 2'b11);
        in_div  = ALU_OP[2];
        // OPERAND1 is signed for MUL/MULH/MULHSU/DIV/REM; OPERAND2 for MUL/MULH/DIV/REM.
        in_neg1 = OPERAND1[XLEN-1] & ~(ALU_OP[1] & ALU_OP[0]) & ~(ALU_OP[2] & ALU_OP[1]);
        in_neg2 = OPERAND2[XLEN-1] & ~ALU_OP[1];
        mag1    = in_neg1 ? -OPERAND1 : OPERAND1;
        mag2    = in_neg2 ? -OPERAND2 : OPERAND2;
        special = 1'b0;
        special_result = '0;
        if (in_div && (OPERAND2 == '0)) begin
            special        = 1'b1;
            special_result = ALU_OP[0] ? OPERAND1 : '1;
        end else if (in_div && !ALU_OP[1] && (OPERAND1 == SMIN) && (OPERAND2 == '1)) begin
            special        = 1'b1;
            special_result = ALU_OP[0] ? '0 : SMIN;
        end
    end

    // One iteration of shift-add multiply and of restoring divide.
    // The divide reuses prod_q as {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, prod_q[XLEN-1:1]};
        div_trial = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]} - {1'b0, b_q};
        if (div_trial[XLEN]) begin
            div_next = {prod_q[2*XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_trial[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end
    end

    // Restore signs and select the architectural result.
    always_comb begin
        mul_fix = (neg1_q ^ neg2_q) ? -prod_q : prod_q;
        q_fix   = (neg1_q ^ neg2_q) ? -prod_q[XLEN-1:0] : prod_q[XLEN-1:0];
        r_fix   = neg1_q ? -prod_q[2*XLEN-1:XLEN] : prod_q[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            fix_result = op_q[0] ? r_fix : q_fix;
        end else begin
            fix_result = (op_q[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
        end
    end

    // Control FSM and datapath registers.
    // The first CALC cycle only loads the iteration register. The 32 counted
    // iterations follow it, which gives a 34-cycle BUSY window.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg1_q   <= 1'b0;
            neg2_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            init_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= ALU_OP[2:0];
                        neg1_q <= in_neg1;
                        neg2_q <= in_neg2;
                        a_q    <= mag1;
                        b_q    <= mag2;
                        cnt_q  <= '0;
                        if (special) begin
                            result_q <= special_result;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            init_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (init_q) begin
                        init_q <= 1'b0;
                        prod_q <= {{XLEN{1'b0}}, (op_q[2] ? a_q : b_q)};
                    end else begin
                        prod_q <= op_q[2] ? div_next : mul_next;
                        cnt_q  <= cnt_q + 1'b1;
                        if (cnt_q == CW'(XLEN - 1)) begin
                            state_q <= S_FIXUP;
                        end
                    end
                end
                S_FIXUP: begin
                    result_q <= fix_result;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode.
    always_comb begin
        BUSY   = (state_q == S_CALC) || (state_q == S_FIXUP);
        DONE   = done_q;
        RESULT = result_q;
    end

endmodule
